fetch_queue: RTL

Parametrised instruction queue between fetch and decode, the multi-issue successor of the single-entry fetch/decode pipeline register. Fetch pushes up to NPUSH instructions per cycle. Decode consumes up to NPOP per cycle from the head. A flush from the hazard/exception path empties the queue in one cycle. The queue decouples i_data_ok latency from decode stalls, so stallF is driven by queue fullness rather than by decode.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_queue_if.sv | 35 +++
 rtl/fetch_queue_chk.sv | 35 +++
 rtl/fetch_queue.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: the fetch entry record and the
// width helpers used to size pointers and counters.
package fetch_queue_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
        logic  addr_err;       // AdEL raised on fetch
        logic  in_delay_slot;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Pointer width for a power-of-two queue depth.
    function automatic int unsigned fq_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Width of a counter that must hold the values 0..n inclusive.
    function automatic int unsigned fq_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode side bundle of the fetch queue. The master drives pushes,
// pops and flush; the slave is the queue itself.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned NPOP  = 2
) ();

    localparam int unsigned PUSH_CNT_W = fq_cnt_w(NPUSH);
    localparam int unsigned POP_CNT_W  = fq_cnt_w(NPOP);
    localparam int unsigned OCC_W      = fq_cnt_w(DEPTH);

    logic                       flush;
    logic                       push_valid;
    logic [PUSH_CNT_W-1:0]      push_count;
    fetch_entry_t [NPUSH-1:0]   push_data;
    logic                       push_ready;
    logic [POP_CNT_W-1:0]       pop_req;
    logic [NPOP-1:0]            out_valid;
    fetch_entry_t [NPOP-1:0]    out_data;
    logic [OCC_W-1:0]           occupancy;

    modport master (
        output flush, push_valid, push_count, push_data, pop_req,
        input  push_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  flush, push_valid, push_count, push_data, pop_req,
        output push_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/fetch_queue_chk.sv
// Simulation-only protocol checks for the fetch queue; carries no logic
// that affects the datapath.
module fetch_queue_chk
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned PUSH_CNT_W = 2,
    parameter int unsigned OCC_W = 4
) (
    input logic                  clk,
    input logic                  resetn,
    input logic                  push_valid,
    input logic [PUSH_CNT_W-1:0] push_count,
    input logic [OCC_W-1:0]      occupancy
);

    // Fetch must never offer more slots than the push port carries.
    push_count_legal_a: assert property (
        @(posedge clk) disable iff (!resetn)
        push_valid |-> (push_count <= PUSH_CNT_W'(NPUSH))
    );

    // Entry accounting stays within the storage.
    occupancy_bound_a: assert property (
        @(posedge clk) disable iff (!resetn)
        occupancy <= OCC_W'(DEPTH)
    );

    // Reset leaves the queue empty on the following cycle.
    reset_empties_a: assert property (
        @(posedge clk) !resetn |=> (occupancy == OCC_W'(0))
    );

endmodule

// File: rtl/fetch_queue.sv
// Multi-issue instruction queue between fetch and decode: up to NPUSH
// entries in and NPOP entries out per cycle, single-cycle flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NPUSH = 2,
    parameter int unsigned NPOP  = 2
) (
    input logic          clk,
    input logic          resetn,
    fetch_queue_if.slave fq
);

    localparam int unsigned PTR_W      = fq_ptr_w(DEPTH);
    localparam int unsigned PUSH_CNT_W = fq_cnt_w(NPUSH);
    localparam int unsigned POP_CNT_W  = fq_cnt_w(NPOP);
    localparam int unsigned OCC_W      = fq_cnt_w(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    // Slot index modulo DEPTH; DEPTH is a power of two so truncation wraps.
    function automatic ptr_t ptr_add(input ptr_t p, input occ_t n);
        occ_t sum;
        sum = OCC_W'(p) + n;
        return sum[PTR_W-1:0];
    endfunction

    ptr_t                  head_r;
    ptr_t                  tail_r;
    occ_t                  occ_r;
    fetch_entry_t          mem_r [DEPTH];

    logic [PUSH_CNT_W-1:0] push_cnt_s;
    occ_t                  push_acc_s;
    occ_t                  pop_req_s;
    occ_t                  pop_acc_s;
    occ_t                  free_s;
    logic                  push_ready_s;
    ptr_t                  head_nxt_s;
    ptr_t                  tail_nxt_s;
    occ_t                  occ_nxt_s;
    ptr_t                  wr_idx_s [NPUSH];
    ptr_t                  rd_idx_s [NPOP];

    // Readiness looks only at registered occupancy, so a same-cycle pop
    // never feeds back into fetch.
    always_comb begin
        free_s       = OCC_W'(DEPTH) - occ_r;
        push_ready_s = (free_s >= OCC_W'(NPUSH));
    end

    // Accepted push and pop counts; oversized requests are clipped.
    always_comb begin
        if (fq.push_count > PUSH_CNT_W'(NPUSH)) begin
            push_cnt_s = PUSH_CNT_W'(NPUSH);
        end else begin
            push_cnt_s = fq.push_count;
        end

        if (fq.push_valid && push_ready_s) begin
            push_acc_s = OCC_W'(push_cnt_s);
        end else begin
            push_acc_s = '0;
        end

        pop_req_s = OCC_W'(fq.pop_req);
        if (pop_req_s > occ_r) begin
            pop_acc_s = occ_r;
        end else begin
            pop_acc_s = pop_req_s;
        end
    end

    // Next pointers, occupancy and per-slot write/read addresses.
    always_comb begin
        head_nxt_s = ptr_add(head_r, pop_acc_s);
        tail_nxt_s = ptr_add(tail_r, push_acc_s);
        occ_nxt_s  = occ_r + push_acc_s - pop_acc_s;
        for (int i = 0; i < NPUSH; i++) begin
            wr_idx_s[i] = ptr_add(tail_r, OCC_W'(i));
        end
        for (int i = 0; i < NPOP; i++) begin
            rd_idx_s[i] = ptr_add(head_r, OCC_W'(i));
        end
    end

    // Pointer and occupancy registers; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (!resetn || fq.flush) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= '0;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            occ_r  <= occ_nxt_s;
        end
    end

    // Entry storage is not reset; a flush drops the same-cycle push.
    always_ff @(posedge clk) begin
        if (resetn && !fq.flush) begin
            for (int i = 0; i < NPUSH; i++) begin
                if (OCC_W'(i) < push_acc_s) begin
                    mem_r[wr_idx_s[i]] <= fq.push_data[i];
                end
            end
        end
    end

    // Head window: depends only on registered state, zero where invalid.
    always_comb begin
        fq.out_valid = '0;
        fq.out_data  = '0;
        for (int i = 0; i < NPOP; i++) begin
            if (occ_r > OCC_W'(i)) begin
                fq.out_valid[i] = 1'b1;
                fq.out_data[i]  = mem_r[rd_idx_s[i]];
            end else begin
                fq.out_valid[i] = 1'b0;
                fq.out_data[i]  = '0;
            end
        end
    end

    assign fq.push_ready = push_ready_s;
    assign fq.occupancy  = occ_r;

    fetch_queue_chk #(
        .DEPTH      (DEPTH),
        .NPUSH      (NPUSH),
        .PUSH_CNT_W (PUSH_CNT_W),
        .OCC_W      (OCC_W)
    ) u_chk (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (fq.push_valid),
        .push_count (fq.push_count),
        .occupancy  (occ_r)
    );

endmodule
